// File: rtl/keycode_action_repeater_if.sv
// Keycode front-end bus: GPIO keycode slots plus action table in, per-action
// press/repeat pulses out. The game-logic side is master, the repeater is slave.
interface keycode_action_repeater_if #(
  parameter int NUM_SLOTS   = 8,
  parameter int NUM_ACTIONS = 6
);
  logic                     tick;
  logic [8*NUM_SLOTS-1:0]   keycodes;
  logic [8*NUM_ACTIONS-1:0] action_codes;
  logic [NUM_ACTIONS-1:0]   repeat_en;
  logic [NUM_ACTIONS-1:0]   action_pulse;
  logic [NUM_ACTIONS-1:0]   held;
  logic                     any_key;

  modport master (
    output tick, keycodes, action_codes, repeat_en,
    input  action_pulse, held, any_key
  );

  modport slave (
    input  tick, keycodes, action_codes, repeat_en,
    output action_pulse, held, any_key
  );
endinterface

// File: rtl/keycode_action_repeater.sv
// Matches registered USB keycode slots against a programmable action table and
// emits per-action press pulses with delayed auto-shift and auto-repeat per frame tick.
module keycode_action_repeater #(
  parameter int NUM_SLOTS   = 8,
  parameter int NUM_ACTIONS = 6,
  parameter int DAS_DELAY   = 16,
  parameter int ARR_PERIOD  = 4,
  parameter int CNT_W       = 8
) (
  input logic                     clk,
  input logic                     reset,
  keycode_action_repeater_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DAS_CMP = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] ARR_CMP = CNT_W'(ARR_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [8*NUM_SLOTS-1:0] kc_q;
  logic [NUM_ACTIONS-1:0] hit;
  logic                   any_nz;
  state_t                 state [NUM_ACTIONS];
  logic [CNT_W-1:0]       cnt   [NUM_ACTIONS];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) kc_q <= '0;
    else       kc_q <= bus.keycodes;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hit    = '0;
    any_nz = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (kc_q[8*s +: 8] != 8'h00) any_nz = 1'b1;
    end
    for (int a = 0; a < NUM_ACTIONS; a++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (bus.action_codes[8*a +: 8] != 8'h00 &&
            kc_q[8*s +: 8] == bus.action_codes[8*a +: 8])
          hit[a] = 1'b1;
      end
    end
  end

  // NOTE: the per-action state/counter arrays are reset explicitly; they are
  // control state, not storage, so a reset must return every action to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < NUM_ACTIONS; a++) begin
        state[a] <= IDLE;
        cnt[a]   <= '0;
      end
      bus.action_pulse <= '0;
      bus.held         <= '0;
      bus.any_key      <= 1'b0;
    end else begin
      bus.any_key      <= any_nz;
      bus.action_pulse <= '0;
      if (bus.tick) begin
        for (int a = 0; a < NUM_ACTIONS; a++) begin
          // Every hit branch lands in a non-IDLE state, so held tracks hit.
          bus.held[a] <= hit[a];
          if (!hit[a]) begin
            state[a] <= IDLE;
            cnt[a]   <= '0;
          end else begin
            case (state[a])
              IDLE: begin
                bus.action_pulse[a] <= 1'b1;
                cnt[a]              <= CNT_ONE;
                state[a]            <= bus.repeat_en[a] ? DELAY : HOLD;
              end
              HOLD: ;
              DELAY: begin
                if (cnt[a] == DAS_CMP) begin
                  bus.action_pulse[a] <= 1'b1;
                  cnt[a]              <= CNT_ONE;
                  state[a]            <= REPEAT;
                end else begin
                  cnt[a] <= cnt[a] + CNT_ONE;
                end
              end
              REPEAT: begin
                if (cnt[a] == ARR_CMP) begin
                  bus.action_pulse[a] <= 1'b1;
                  cnt[a]              <= CNT_ONE;
                end else begin
                  cnt[a] <= cnt[a] + CNT_ONE;
                end
              end
              default: state[a] <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule
